// File: rtl/mux_scan_sequencer_if.sv
// Control/data bundle between a scan controller (master) and mux_scan_sequencer (slave).
// Master drives start/stop/cont/en_mask/dwell/din; slave returns s/a/sel_stb/busy/done/err/scan_cnt.
// Parameter widths must match the ones given to the sequencer instance.
interface mux_scan_sequencer_if #(
   parameter int DWELL_W = 8,
   parameter int CNT_W   = 8
);
   logic               start;
   logic               stop;
   logic               cont;
   logic [3:0]         en_mask;
   logic [DWELL_W-1:0] dwell;
   logic [3:0]         din;
   logic [1:0]         s;
   logic [3:0]         a;
   logic               sel_stb;
   logic               busy;
   logic               done;
   logic               err;
   logic [CNT_W-1:0]   scan_cnt;

   modport master (
      output start, stop, cont, en_mask, dwell, din,
      input  s, a, sel_stb, busy, done, err, scan_cnt
   );

   modport slave (
      input  start, stop, cont, en_mask, dwell, din,
      output s, a, sel_stb, busy, done, err, scan_cnt
   );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a 2-bit channel select through enabled channels, holding each for dwell+1 cycles.
// Latency: s/a/sel_stb/busy change on the edge after start is seen; all outputs registered.
// No backpressure: stop is sticky and takes effect at the end of the current dwell.
//
// Ports: clk, rst_n (async active-low) plus bus (slave modport):
//   in : start, stop, cont, en_mask[3:0], dwell[DWELL_W-1:0], din[3:0]
//   out: s[1:0], a[3:0], sel_stb, busy, done, err, scan_cnt[CNT_W-1:0]
module mux_scan_sequencer #(
   parameter int DWELL_W = 8,
   parameter int CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mux_scan_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [3:0]         mask_q;
   logic               cont_q;
   logic               stop_pend_q;
   logic [1:0]         s_q;
   logic [3:0]         a_q;
   logic               sel_stb_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;
   logic [CNT_W-1:0]   scan_cnt_q;

   logic [1:0]         nxt_hi_d;
   logic               nxt_hi_vld_d;
   logic               pass_done_d;
   logic [1:0]         nxt_ch_d;
   logic               stop_now_d;
   logic               at_end_d;

   function automatic logic [1:0] lowest_ch(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   // Next enabled channel strictly above the current select; descending
   // scan so the closest higher channel wins.
   always_comb begin
      nxt_hi_d     = 2'd0;
      nxt_hi_vld_d = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(s_q))) begin
            nxt_hi_d     = 2'(i);
            nxt_hi_vld_d = 1'b1;
         end
      end
   end

   assign pass_done_d = !nxt_hi_vld_d;
   assign nxt_ch_d    = pass_done_d ? lowest_ch(mask_q) : nxt_hi_d;
   // A stop arriving in the boundary cycle itself must still terminate there.
   assign stop_now_d  = stop_pend_q | bus.stop;
   assign at_end_d    = (cnt_q == dwell_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dwell_q     <= '0;
         mask_q      <= '0;
         cont_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         s_q         <= 2'd0;
         a_q         <= 4'd0;
         sel_stb_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         scan_cnt_q  <= '0;
      end else begin
         sel_stb_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               busy_q      <= 1'b0;
               stop_pend_q <= 1'b0;
               // start together with stop is dropped silently
               if (bus.start && !bus.stop) begin
                  if (bus.en_mask == 4'd0) begin
                     err_q <= 1'b1;
                  end else begin
                     mask_q    <= bus.en_mask;
                     dwell_q   <= bus.dwell;
                     cont_q    <= bus.cont;
                     s_q       <= lowest_ch(bus.en_mask);
                     a_q       <= bus.din;
                     cnt_q     <= '0;
                     sel_stb_q <= 1'b1;
                     busy_q    <= 1'b1;
                     state_q   <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (bus.stop) stop_pend_q <= 1'b1;
               if (at_end_d) begin
                  cnt_q <= '0;
                  if (pass_done_d) scan_cnt_q <= scan_cnt_q + CNT_W'(1);
                  if ((pass_done_d && !cont_q) || stop_now_d) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     s_q       <= nxt_ch_d;
                     a_q       <= bus.din;
                     sel_stb_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + DWELL_W'(1);
               end
            end
            DONE: begin
               busy_q      <= 1'b0;
               stop_pend_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.s        = s_q;
   assign bus.a        = a_q;
   assign bus.sel_stb  = sel_stb_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.scan_cnt = scan_cnt_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed vector bench for mux_scan_sequencer with a 2-bit scan counter so wrap is reachable.
// Each vector: inputs driven at negedge, outputs compared 1 time unit after the next posedge.
// Reset behaviour (initial and mid-scan asynchronous) is exercised by hand-written sequences.
module tb_mux_scan_sequencer;
   localparam int DW = 8;
   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mux_scan_sequencer_if #(.DWELL_W(DW), .CNT_W(CW)) bus();

   mux_scan_sequencer #(.DWELL_W(DW), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic          start;
      logic          stop;
      logic          cont;
      logic [3:0]    mask;
      logic [DW-1:0] dwell;
      logic [3:0]    din;
      logic [1:0]    s;
      logic [3:0]    a;
      logic          sel;
      logic          busy;
      logic          done;
      logic          err;
      logic [CW-1:0] cnt;
   } vec_t;

   vec_t vq[$];
   int   errors = 0;
   int   checks = 0;

   task automatic add(input logic st, input logic sp, input logic ct, input logic [3:0] m,
                      input int dw, input logic [3:0] d,
                      input logic [1:0] es, input logic [3:0] ea, input logic esel,
                      input logic ebusy, input logic edone, input logic eerr, input int ecnt);
      vec_t v;
      v.start = st;  v.stop = sp;  v.cont = ct;  v.mask = m;
      v.dwell = DW'(dw);  v.din = d;
      v.s = es;  v.a = ea;  v.sel = esel;  v.busy = ebusy;
      v.done = edone;  v.err = eerr;  v.cnt = CW'(ecnt);
      vq.push_back(v);
   endtask

   task automatic drive(input logic st, input logic sp, input logic ct, input logic [3:0] m,
                        input logic [DW-1:0] dw, input logic [3:0] d);
      bus.start = st;  bus.stop = sp;  bus.cont = ct;
      bus.en_mask = m;  bus.dwell = dw;  bus.din = d;
   endtask

   task automatic check(input string name, input logic [1:0] es, input logic [3:0] ea,
                        input logic esel, input logic ebusy, input logic edone,
                        input logic eerr, input logic [CW-1:0] ecnt);
      checks++;
      if ({bus.s, bus.a, bus.sel_stb, bus.busy, bus.done, bus.err, bus.scan_cnt} !==
          {es, ea, esel, ebusy, edone, eerr, ecnt}) begin
         errors++;
         $display("FAIL %s: got s=%0d a=%h stb=%b busy=%b done=%b err=%b cnt=%0d, expected s=%0d a=%h stb=%b busy=%b done=%b err=%b cnt=%0d",
                  name, bus.s, bus.a, bus.sel_stb, bus.busy, bus.done, bus.err, bus.scan_cnt,
                  es, ea, esel, ebusy, edone, eerr, ecnt);
      end
   endtask

   initial begin
      // single pass: mask 1011, dwell 2 -> s 0,0,0,1,1,1,3,3,3 then done
      add(1,0,0,4'hB,2,4'h5, 0,4'h5,1,1,0,0,0);
      add(0,0,0,4'hB,2,4'h6, 0,4'h5,0,1,0,0,0);
      add(0,0,0,4'hB,2,4'h7, 0,4'h5,0,1,0,0,0);
      add(0,0,0,4'hB,2,4'h8, 1,4'h8,1,1,0,0,0);
      add(0,0,0,4'hB,2,4'h9, 1,4'h8,0,1,0,0,0);
      add(0,0,0,4'hB,2,4'hA, 1,4'h8,0,1,0,0,0);
      add(0,0,0,4'hB,2,4'hB, 3,4'hB,1,1,0,0,0);
      add(0,0,0,4'hB,2,4'hC, 3,4'hB,0,1,0,0,0);
      add(0,0,0,4'hB,2,4'hD, 3,4'hB,0,1,0,0,0);
      add(0,0,0,4'hB,2,4'hE, 3,4'hB,0,0,1,0,1);
      // start during DONE ignored; start+stop ignored; zero mask -> err
      add(1,0,0,4'hB,2,4'h1, 3,4'hB,0,0,0,0,1);
      add(1,1,0,4'hF,2,4'h2, 3,4'hB,0,0,0,0,1);
      add(1,0,0,4'h0,2,4'h3, 3,4'hB,0,0,0,1,1);
      add(0,0,0,4'h0,2,4'h3, 3,4'hB,0,0,0,0,1);
      // continuous, dwell 0, stop while s=1 in second pass
      add(1,0,1,4'hF,0,4'h1, 0,4'h1,1,1,0,0,1);
      add(0,0,1,4'hF,0,4'h2, 1,4'h2,1,1,0,0,1);
      add(0,0,1,4'hF,0,4'h3, 2,4'h3,1,1,0,0,1);
      add(0,0,1,4'hF,0,4'h4, 3,4'h4,1,1,0,0,1);
      add(0,0,1,4'hF,0,4'h5, 0,4'h5,1,1,0,0,2);
      add(0,0,1,4'hF,0,4'h6, 1,4'h6,1,1,0,0,2);
      add(0,1,1,4'hF,0,4'h7, 1,4'h6,0,0,1,0,2);
      add(0,0,1,4'hF,0,4'h8, 1,4'h6,0,0,0,0,2);
      // latch isolation: dwell/mask/cont changed mid-scan have no effect
      add(1,0,0,4'h6,1,4'h9, 1,4'h9,1,1,0,0,2);
      add(0,0,1,4'h0,5,4'hA, 1,4'h9,0,1,0,0,2);
      add(0,0,1,4'h0,5,4'hB, 2,4'hB,1,1,0,0,2);
      add(0,0,1,4'h0,5,4'hC, 2,4'hB,0,1,0,0,2);
      add(0,0,1,4'h0,5,4'hD, 2,4'hB,0,0,1,0,3);
      add(0,0,0,4'h0,0,4'h0, 2,4'hB,0,0,0,0,3);
      // single channel, dwell 3: scan_cnt wraps 3 -> 0, sticky stop mid-dwell
      add(1,0,1,4'h4,3,4'h3, 2,4'h3,1,1,0,0,3);
      add(0,0,1,4'h4,3,4'h4, 2,4'h3,0,1,0,0,3);
      add(0,0,1,4'h4,3,4'h5, 2,4'h3,0,1,0,0,3);
      add(0,0,1,4'h4,3,4'h6, 2,4'h3,0,1,0,0,3);
      add(0,0,1,4'h4,3,4'h7, 2,4'h7,1,1,0,0,0);
      add(0,1,1,4'h4,3,4'h8, 2,4'h7,0,1,0,0,0);
      add(0,0,1,4'h4,3,4'h9, 2,4'h7,0,1,0,0,0);
      add(0,0,1,4'h4,3,4'hA, 2,4'h7,0,1,0,0,0);
      add(0,0,1,4'h4,3,4'hB, 2,4'h7,0,0,1,0,1);
      add(0,0,0,4'h0,0,4'h0, 2,4'h7,0,0,0,0,1);
      // pending stop must not survive into the next scan
      add(1,0,1,4'h4,0,4'hF, 2,4'hF,1,1,0,0,1);
      add(0,0,1,4'h4,0,4'hE, 2,4'hE,1,1,0,0,2);
      add(0,1,1,4'h4,0,4'hD, 2,4'hE,0,0,1,0,3);
      add(0,0,0,4'h0,0,4'h0, 2,4'hE,0,0,0,0,3);

      rst_n = 1'b0;
      drive(0, 0, 0, 4'h0, '0, 4'h0);
      #12;
      check("reset_state", 2'd0, 4'h0, 0, 0, 0, 0, '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i].start, vq[i].stop, vq[i].cont, vq[i].mask, vq[i].dwell, vq[i].din);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vq[i].s, vq[i].a, vq[i].sel, vq[i].busy,
               vq[i].done, vq[i].err, vq[i].cnt);
      end

      // asynchronous reset while busy at s = 2
      @(negedge clk);
      drive(1, 0, 1, 4'hF, '0, 4'h5);
      @(posedge clk); #1;
      check("rst_pre_s0", 2'd0, 4'h5, 1, 1, 0, 0, CW'(3));
      @(negedge clk);
      drive(0, 0, 1, 4'hF, '0, 4'h6);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_pre_s2", 2'd2, 4'h6, 1, 1, 0, 0, CW'(3));
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async", 2'd0, 4'h0, 0, 0, 0, 0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 4'h0, '0, 4'h0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check($sformatf("rst_after%0d", k), 2'd0, 4'h0, 0, 0, 0, 0, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
